// File: rtl/cic_integ_decim.sv
// CIC integrator cascade plus decimator: integrates at the input rate and emits
// the last integrator every DECIM accepted samples. Optional clear: CIC_INTEG_CLR_EN.
module cic_integ_decim #(
  parameter int WIDTH    = 32,
  parameter int IN_WIDTH = 1,
  parameter int STAGES   = 4,
  parameter int DECIM    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [IN_WIDTH-1:0] data_in,
`ifdef CIC_INTEG_CLR_EN
  input  logic                clr,
`endif
  output logic [WIDTH-1:0]    data_out,
  output logic                ena_out
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_integ      [STAGES];
  logic [WIDTH-1:0] w_integ_next [STAGES];
  logic             w_clr;
  logic             w_last;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_ena_out;

`ifdef CIC_INTEG_CLR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  // A 1-bit bitstream maps to +/-1; wider samples are signed and sign-extended.
  generate
    if (IN_WIDTH == 1) begin : g_bitstream
      assign w_x = data_in[0] ? WIDTH'(1) : {WIDTH{1'b1}};
    end else begin : g_sample
      assign w_x = WIDTH'($signed(data_in));
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [WIDTH-1:0] r_integ;
      logic [WIDTH-1:0] w_addend;

      if (gi == 0) begin : g_first
        assign w_addend = w_x;
      end else begin : g_rest
        assign w_addend = w_integ[gi-1];
      end

      assign w_integ[gi]      = r_integ;
      assign w_integ_next[gi] = r_integ + w_addend;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_integ <= '0;
        end else if (w_clr) begin
          r_integ <= '0;
        end else if (in_valid) begin
          r_integ <= w_integ_next[gi];
        end
      end
    end
  endgenerate

  assign w_last = (r_cnt == CNT_LAST);

  // The output captures the last stage's next value, so the strobe lands on
  // the same edge that accepts the final sample of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_data_out <= '0;
      r_ena_out  <= 1'b0;
    end else if (w_clr) begin
      r_cnt     <= '0;
      r_ena_out <= 1'b0;
    end else begin
      r_ena_out <= in_valid & w_last;
      if (in_valid) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_data_out <= w_integ_next[STAGES-1];
        end
      end
    end
  end

  assign data_out = r_data_out;
  assign ena_out  = r_ena_out;

endmodule

// File: tb/tb_cic_integ_decim.sv
// Bench for cic_integ_decim: four parameterisations, reference model feeding a
// strobe scoreboard, plus literal expected frame values.
module tb_cic_integ_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
`ifdef CIC_INTEG_CLR_EN
  logic        clr;
`endif
  logic        v0, v1, v2, v3;
  logic        x0, x1, x3;
  logic [7:0]  x2;
  logic [31:0] q0, q1, q3;
  logic [7:0]  q2;
  logic        e0, e1, e2, e3;

  int checks = 0;
  int errors = 0;

  localparam int P_W  [4] = '{32, 32, 8, 32};
  localparam int P_S  [4] = '{1, 2, 1, 4};
  localparam int P_D  [4] = '{4, 4, 2, 64};
  localparam int P_IN [4] = '{1, 1, 8, 1};

  cic_integ_decim #(.WIDTH(32), .IN_WIDTH(1), .STAGES(1), .DECIM(4)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(v0), .data_in(x0),
`ifdef CIC_INTEG_CLR_EN
    .clr(clr),
`endif
    .data_out(q0), .ena_out(e0));

  cic_integ_decim #(.WIDTH(32), .IN_WIDTH(1), .STAGES(2), .DECIM(4)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(v1), .data_in(x1),
`ifdef CIC_INTEG_CLR_EN
    .clr(clr),
`endif
    .data_out(q1), .ena_out(e1));

  cic_integ_decim #(.WIDTH(8), .IN_WIDTH(8), .STAGES(1), .DECIM(2)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v2), .data_in(x2),
`ifdef CIC_INTEG_CLR_EN
    .clr(clr),
`endif
    .data_out(q2), .ena_out(e2));

  cic_integ_decim u_def (
    .clk(clk), .rst(rst), .in_valid(v3), .data_in(x3),
`ifdef CIC_INTEG_CLR_EN
    .clr(clr),
`endif
    .data_out(q3), .ena_out(e3));

  // reference model and scoreboard
  logic [63:0] m_i [8];
  int          m_cnt;
  logic [63:0] m_out;
  logic [63:0] exp_q [$];
  logic        exp_ena_q [$];
  logic [63:0] exp_hold_q [$];
  logic        obs_ena_q [$];
  logic [63:0] obs_data_q [$];
  logic [63:0] obs_strobe_q [$];

  task automatic clear_sb();
    for (int k = 0; k < 8; k++) m_i[k] = '0;
    m_cnt = 0;
    m_out = '0;
    exp_q.delete();
    exp_ena_q.delete();
    exp_hold_q.delete();
    obs_ena_q.delete();
    obs_data_q.delete();
    obs_strobe_q.delete();
  endtask

  task automatic model_step(input int d, input logic v, input logic [7:0] x,
                            input logic c, output logic ena);
    logic [63:0] mask;
    logic [63:0] xi;
    logic [63:0] prev [8];
    mask = (64'd1 << P_W[d]) - 64'd1;
    ena = 1'b0;
    if (c) begin
      for (int k = 0; k < 8; k++) m_i[k] = '0;
      m_cnt = 0;
    end else if (v) begin
      if (P_IN[d] == 1) xi = x[0] ? 64'd1 : {64{1'b1}};
      else              xi = {{56{x[7]}}, x};
      prev = m_i;
      m_i[0] = (prev[0] + xi) & mask;
      for (int k = 1; k < P_S[d]; k++) m_i[k] = (prev[k] + prev[k-1]) & mask;
      if (m_cnt == P_D[d] - 1) begin
        m_cnt = 0;
        m_out = m_i[P_S[d]-1];
        ena = 1'b1;
        exp_q.push_back(m_out);
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic drive_cycle(input int d, input logic v, input logic [7:0] x, input logic c);
    logic        ee;
    logic        eo;
    logic [63:0] dd;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    case (d)
      0:       begin v0 = v; x0 = x[0]; end
      1:       begin v1 = v; x1 = x[0]; end
      2:       begin v2 = v; x2 = x;    end
      default: begin v3 = v; x3 = x[0]; end
    endcase
`ifdef CIC_INTEG_CLR_EN
    clr = c;
`endif
    model_step(d, v, x, c, ee);
    exp_ena_q.push_back(ee);
    exp_hold_q.push_back(m_out);
    @(posedge clk);
    #1;
    case (d)
      0:       begin eo = e0; dd = {32'd0, q0}; end
      1:       begin eo = e1; dd = {32'd0, q1}; end
      2:       begin eo = e2; dd = {56'd0, q2}; end
      default: begin eo = e3; dd = {32'd0, q3}; end
    endcase
    obs_ena_q.push_back(eo);
    obs_data_q.push_back(dd);
    if (eo === 1'b1) begin
      obs_strobe_q.push_back(dd);
      $display("[%0t] dut%0d strobe data_out=%0d", $time, d, dd);
    end
  endtask

  task automatic apply_reset();
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    x0 = 1'b0; x1 = 1'b0; x2 = 8'd0; x3 = 1'b0;
`ifdef CIC_INTEG_CLR_EN
    clr = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_sb();
  endtask

  task automatic test_reset();
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    x0 = 1'b0; x1 = 1'b0; x2 = 8'd0; x3 = 1'b0;
`ifdef CIC_INTEG_CLR_EN
    clr = 1'b0;
`endif
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (e0 !== 1'b0 || e1 !== 1'b0 || e2 !== 1'b0 || e3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ena: got %b%b%b%b required 0000", e0, e1, e2, e3);
    end
    checks++;
    if (q0 !== 32'd0 || q1 !== 32'd0 || q2 !== 8'd0 || q3 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: got %0d %0d %0d %0d required all 0", q0, q1, q2, q3);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
  endtask

  task automatic test_const_one();
    logic [63:0] want [3] = '{64'd4, 64'd8, 64'd12};
    logic [63:0] sb;
    apply_reset();
    for (int k = 0; k < 12; k++) drive_cycle(0, 1'b1, 8'd1, 1'b0);
    foreach (obs_ena_q[k]) begin
      checks++;
      if (obs_ena_q[k] !== exp_ena_q[k] || obs_data_q[k] !== exp_hold_q[k]) begin
        errors++;
        $display("FAIL const_one cycle %0d: ena_out=%b data_out=%0d required ena_out=%b data_out=%0d",
                 k, obs_ena_q[k], obs_data_q[k], exp_ena_q[k], exp_hold_q[k]);
      end
    end
    checks++;
    if (obs_strobe_q.size() != 3) begin
      errors++;
      $display("FAIL const_one strobe_count: got %0d required 3", obs_strobe_q.size());
    end
    foreach (obs_strobe_q[k]) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (k >= 3 || obs_strobe_q[k] !== sb || obs_strobe_q[k] !== want[k]) begin
        errors++;
        $display("FAIL const_one strobe %0d: got %0d required %0d", k, obs_strobe_q[k], sb);
      end
    end
  endtask

  task automatic test_two_stage();
    logic [63:0] want [2] = '{64'd6, 64'd28};
    logic [63:0] sb;
    apply_reset();
    for (int k = 0; k < 8; k++) drive_cycle(1, 1'b1, 8'd1, 1'b0);
    foreach (obs_ena_q[k]) begin
      checks++;
      if (obs_ena_q[k] !== exp_ena_q[k] || obs_data_q[k] !== exp_hold_q[k]) begin
        errors++;
        $display("FAIL two_stage cycle %0d: ena_out=%b data_out=%0d required ena_out=%b data_out=%0d",
                 k, obs_ena_q[k], obs_data_q[k], exp_ena_q[k], exp_hold_q[k]);
      end
    end
    checks++;
    if (obs_strobe_q.size() != 2) begin
      errors++;
      $display("FAIL two_stage strobe_count: got %0d required 2", obs_strobe_q.size());
    end
    foreach (obs_strobe_q[k]) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (k >= 2 || obs_strobe_q[k] !== sb || obs_strobe_q[k] !== want[k]) begin
        errors++;
        $display("FAIL two_stage strobe %0d: got %0d required %0d", k, obs_strobe_q[k], sb);
      end
    end
  endtask

  task automatic test_gapped();
    logic [63:0] want [2] = '{64'd4, 64'd8};
    logic [63:0] sb;
    apply_reset();
    for (int k = 0; k < 16; k++) drive_cycle(0, (k % 2) == 0, 8'd1, 1'b0);
    foreach (obs_ena_q[k]) begin
      checks++;
      if (obs_ena_q[k] !== exp_ena_q[k] || obs_data_q[k] !== exp_hold_q[k]) begin
        errors++;
        $display("FAIL gapped cycle %0d: ena_out=%b data_out=%0d required ena_out=%b data_out=%0d",
                 k, obs_ena_q[k], obs_data_q[k], exp_ena_q[k], exp_hold_q[k]);
      end
    end
    checks++;
    if (obs_ena_q.size() != 16 || obs_ena_q[6] !== 1'b1 || obs_ena_q[14] !== 1'b1) begin
      errors++;
      $display("FAIL gapped strobe_timing: strobes not on clocks 7 and 15");
    end
    foreach (obs_strobe_q[k]) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (k >= 2 || obs_strobe_q[k] !== sb || obs_strobe_q[k] !== want[k]) begin
        errors++;
        $display("FAIL gapped strobe %0d: got %0d required %0d", k, obs_strobe_q[k], sb);
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] want [3] = '{64'd200, 64'd144, 64'd88};
    logic [63:0] sb;
    logic [7:0]  prev;
    logic [7:0]  diff;
    apply_reset();
    for (int k = 0; k < 6; k++) drive_cycle(2, 1'b1, 8'd100, 1'b0);
    foreach (obs_ena_q[k]) begin
      checks++;
      if (obs_ena_q[k] !== exp_ena_q[k] || obs_data_q[k] !== exp_hold_q[k]) begin
        errors++;
        $display("FAIL wrap cycle %0d: ena_out=%b data_out=%0d required ena_out=%b data_out=%0d",
                 k, obs_ena_q[k], obs_data_q[k], exp_ena_q[k], exp_hold_q[k]);
      end
    end
    checks++;
    if (obs_strobe_q.size() != 3) begin
      errors++;
      $display("FAIL wrap strobe_count: got %0d required 3", obs_strobe_q.size());
    end
    prev = 8'd0;
    foreach (obs_strobe_q[k]) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (k >= 3 || obs_strobe_q[k] !== sb || obs_strobe_q[k] !== want[k]) begin
        errors++;
        $display("FAIL wrap strobe %0d: got %0d required %0d", k, obs_strobe_q[k], sb);
      end
      // a downstream comb differentiates modulo 2^8; the wrap must cancel
      diff = obs_strobe_q[k][7:0] - prev;
      prev = obs_strobe_q[k][7:0];
      checks++;
      if (diff !== 8'd200) begin
        errors++;
        $display("FAIL wrap comb_diff %0d: got %0d required 200", k, diff);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] sb;
    apply_reset();
    for (int k = 0; k < 6; k++) drive_cycle(0, 1'b1, 8'd1, 1'b0);
    checks++;
    if (q0 !== 32'd4) begin
      errors++;
      $display("FAIL reset_mid pre_data: got %0d required 4", q0);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (q0 !== 32'd0 || e0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid async: data_out=%0d ena_out=%b required 0 0", q0, e0);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_sb();
    for (int k = 0; k < 4; k++) drive_cycle(0, 1'b1, 8'd1, 1'b0);
    foreach (obs_ena_q[k]) begin
      checks++;
      if (obs_ena_q[k] !== exp_ena_q[k] || obs_data_q[k] !== exp_hold_q[k]) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: ena_out=%b data_out=%0d required ena_out=%b data_out=%0d",
                 k, obs_ena_q[k], obs_data_q[k], exp_ena_q[k], exp_hold_q[k]);
      end
    end
    checks++;
    if (obs_strobe_q.size() != 1 || obs_ena_q[3] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid strobe: got %0d strobes required 1 on 4th sample", obs_strobe_q.size());
    end
    foreach (obs_strobe_q[k]) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (obs_strobe_q[k] !== sb || obs_strobe_q[k] !== 64'd4) begin
        errors++;
        $display("FAIL reset_mid strobe %0d: got %0d required 4", k, obs_strobe_q[k]);
      end
    end
  endtask

  task automatic test_random_default();
    logic [63:0] sb;
    logic        v;
    int          accepted;
    accepted = 0;
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) accepted++;
      drive_cycle(3, v, 8'($urandom_range(0, 1)), 1'b0);
    end
    foreach (obs_ena_q[k]) begin
      checks++;
      if (obs_ena_q[k] !== exp_ena_q[k] || obs_data_q[k] !== exp_hold_q[k]) begin
        errors++;
        $display("FAIL random cycle %0d: ena_out=%b data_out=%0d required ena_out=%b data_out=%0d",
                 k, obs_ena_q[k], obs_data_q[k], exp_ena_q[k], exp_hold_q[k]);
      end
    end
    checks++;
    if (obs_strobe_q.size() != accepted / 64) begin
      errors++;
      $display("FAIL random strobe_count: got %0d required %0d", obs_strobe_q.size(), accepted / 64);
    end
    foreach (obs_strobe_q[k]) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (obs_strobe_q[k] !== sb) begin
        errors++;
        $display("FAIL random strobe %0d: got %0d required %0d", k, obs_strobe_q[k], sb);
      end
    end
  endtask

`ifdef CIC_INTEG_CLR_EN
  task automatic test_clr();
    logic [63:0] want [2] = '{64'd4, 64'd4};
    logic [63:0] sb;
    apply_reset();
    for (int k = 0; k < 11; k++) drive_cycle(0, 1'b1, 8'd1, k == 6);
    foreach (obs_ena_q[k]) begin
      checks++;
      if (obs_ena_q[k] !== exp_ena_q[k] || obs_data_q[k] !== exp_hold_q[k]) begin
        errors++;
        $display("FAIL clr cycle %0d: ena_out=%b data_out=%0d required ena_out=%b data_out=%0d",
                 k, obs_ena_q[k], obs_data_q[k], exp_ena_q[k], exp_hold_q[k]);
      end
    end
    checks++;
    if (obs_strobe_q.size() != 2 || obs_ena_q[10] !== 1'b1) begin
      errors++;
      $display("FAIL clr strobe: got %0d strobes required 2, second on clock 11", obs_strobe_q.size());
    end
    foreach (obs_strobe_q[k]) begin
      sb = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
      checks++;
      if (k >= 2 || obs_strobe_q[k] !== sb || obs_strobe_q[k] !== want[k]) begin
        errors++;
        $display("FAIL clr strobe %0d: got %0d required %0d", k, obs_strobe_q[k], sb);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_const_one();
    test_two_stage();
    test_gapped();
    test_wrap();
    test_reset_mid();
    test_random_default();
`ifdef CIC_INTEG_CLR_EN
    test_clr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_integ_decim.md
# cic_integ_decim

Integrator-and-decimate front end of the multi-stage CIC decimation filter. It runs a cascade of `STAGES` integrators at the modulator sample rate, counts accepted input samples, and every `DECIM`-th sample emits the last integrator value with a one-cycle `ena_out` strobe. `data_out` and `ena_out` connect directly to `data_in` and `ena` of the first `cic_comb` in the comb chain.

## Interface
- `WIDTH`, 32: accumulator and output width; two's-complement; all arithmetic is modulo 2^WIDTH.
- `IN_WIDTH`, 1: input sample width. 1 means a raw sigma-delta bitstream; >1 means a signed sample.
- `STAGES`, 4: number of cascaded integrators, 1..8.
- `DECIM`, 64: decimation ratio, 2..65536.
- One clock `clk`; reset `rst` is asynchronous and active-low.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `data_in` is a valid sample this cycle.
- `data_in` in IN_WIDTH: input sample.
- `clr` in 1: synchronous clear. Present only with `CIC_INTEG_CLR_EN`.
- `data_out` out WIDTH: decimated integrator output; held between strobes.
- `ena_out` out 1: one-cycle strobe marking a new `data_out`; drives the comb stage `ena`.

## Operation
- Input mapping, producing x (WIDTH bits):
  - IN_WIDTH==1: bit 1 → +1, bit 0 → −1.
  - Otherwise: `data_in` is sign-extended to WIDTH.
- Integrator registers i1..iS (S = STAGES) are pipelined. On a cycle with `in_valid`=1, all updates use pre-edge values:
  - i1 ← i1 + x
  - ik ← ik + i(k−1), for k = 2..S
- With `in_valid`=0, the integrators and the counter hold.
- Decimation counter `cnt` counts accepted samples, 0..DECIM−1. On each `in_valid` it increments, wrapping DECIM−1 → 0.
- When `in_valid`=1 and `cnt`==DECIM−1:
  - `data_out` ← iS_next, the value iS takes at this same edge.
  - `ena_out` ← 1.
- In every other cycle `ena_out` ← 0 and `data_out` holds.
- Overflow wraps silently, with no saturation. The downstream combs cancel the wrap provided WIDTH ≥ IN_WIDTH + STAGES·ceil(log2 DECIM). This is a documented integration rule and is not checked in RTL.
- No backpressure: downstream must accept every `ena_out` strobe.

## Timing
- Reset (`rst`=0, asynchronous): i1..iS = 0, `cnt` = 0, `data_out` = 0, `ena_out` = 0.
- Reset deassertion: the first `in_valid` may arrive on the first edge after `rst` rises.
- Reset asserted mid-frame: the partial frame is discarded. Counting restarts at 0 and no strobe is produced for the partial frame.
- Latency: `data_out`/`ena_out` update on the same edge that accepts the DECIM-th sample of a frame.
- Strobe spacing is exactly DECIM accepted samples. `ena_out` is never high on two consecutive cycles, since DECIM ≥ 2.
- Throughput: one sample per clock when `in_valid` is held high; gaps in `in_valid` simply stretch the frame.

## Configuration
- `CIC_INTEG_CLR_EN` defined:
  - Adds the `clr` input.
  - `clr`=1 at an edge zeroes i1..iS and `cnt`, and forces `ena_out`=0; `data_out` holds its last value.
  - `clr` has priority over a simultaneous `in_valid`; that sample is dropped.
- `CIC_INTEG_CLR_EN` undefined: no `clr` port and no clear logic; only `rst` initialises state.

## Test plan
- Constant +1 input:
  - Stimulus: STAGES=1, DECIM=4, IN_WIDTH=1, `data_in`=1 with `in_valid` held high from reset.
  - Response: `ena_out` pulses on the 4th, 8th and 12th accepted samples, with `data_out` = 4, 8, 12.
- Two-stage cascade:
  - Stimulus: STAGES=2, DECIM=4, constant +1 input.
  - Response: i2 sequence is 0,1,3,6,10,…; first strobe gives `data_out`=6 and the second gives 28.
- Gapped valid:
  - Stimulus: STAGES=1, DECIM=4, `in_valid` toggling 1,0,1,0….
  - Response: strobes every 8 clocks, `data_out` = 4, 8; values are identical to the ungapped run.
- Wrap-around:
  - Stimulus: WIDTH=8, STAGES=1, DECIM=2, IN_WIDTH=8, constant input 100.
  - Response: `data_out` = 200, then 144 (400 mod 256), then 88.
  - A cic_comb attached downstream outputs a constant 200 (i.e. −56 interpreted as int8) after its first strobe, proving the wrap cancels.
- Reset mid-frame:
  - Stimulus: DECIM=4; assert `rst` low after 2 accepted samples, then release.
  - Response: all outputs are 0 immediately on assertion (asynchronous); the next strobe occurs after 4 fresh samples.
- `clr` (with `CIC_INTEG_CLR_EN`):
  - Stimulus: STAGES=1, DECIM=4, constant +1; pulse `clr` together with the 3rd sample.
  - Response: no strobe for that frame; the next strobe arrives after 4 further samples with `data_out`=4.
